// File: rtl/shot_hit_detector.sv
// Per-frame scan of the eight shot slots against a latched duck box; reports hit pulse, slot, kill mask and score.
// Optional build macro MULTI_HIT_EN: record every overlapping slot instead of only the first one.
module shot_hit_detector #(
    parameter int DUCK_W    = 32,
    parameter int DUCK_H    = 32,
    parameter int SHOT_W    = 4,
    parameter int SHOT_H    = 8,
    parameter int SCORE_MAX = 999
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        scan_start,
    input  logic [79:0] shot_x_bus,
    input  logic [79:0] shot_y_bus,
    input  logic [7:0]  shot_valid,
    input  logic [9:0]  duck_x,
    input  logic [9:0]  duck_y,
    input  logic        duck_alive,
    output logic        busy,
    output logic        hit,
    output logic [2:0]  hit_slot,
    output logic [7:0]  kill_mask,
    output logic [9:0]  score
);

    typedef enum logic [1:0] {IDLE, SCAN, REPORT} state_t;

    state_t      state_q;
    logic [9:0]  dx_q, dy_q;
    logic        alive_q;
    logic [2:0]  idx_q;
    logic [7:0]  mask_q, mask_d;
    logic        busy_q, hit_q;
    logic [2:0]  slot_q;
    logic [7:0]  kill_q;
    logic [9:0]  score_q;

    logic [9:0]  sx, sy;
    logic [10:0] sx_w, sy_w, dx_w, dy_w;
    logic        slot_hit;

    function automatic logic [2:0] lowest_set(input logic [7:0] m);
        logic [2:0] r;
        r = 3'd0;
        for (int i = 7; i >= 0; i--)
            if (m[i]) r = 3'(i);
        return r;
    endfunction

    function automatic logic [3:0] popcount(input logic [7:0] m);
        logic [3:0] c;
        c = 4'd0;
        for (int i = 0; i < 8; i++)
            c = c + {3'b000, m[i]};
        return c;
    endfunction

    function automatic logic [9:0] sat_add(input logic [9:0] s, input logic [3:0] n);
        logic [10:0] sum;
        sum = {1'b0, s} + {7'b0, n};
        if (sum >= 11'(SCORE_MAX))
            return 10'(SCORE_MAX);
        return sum[9:0];
    endfunction

    always_comb begin
        sx = 10'd0;
        sy = 10'd0;
        for (int i = 0; i < 8; i++) begin
            if (idx_q == 3'(i)) begin
                sx = shot_x_bus[10*i +: 10];
                sy = shot_y_bus[10*i +: 10];
            end
        end
    end

    // 11-bit compares so box sums never wrap; sy is only treated as unsigned once its sign bit is known clear
    assign sx_w = {1'b0, sx};
    assign sy_w = {1'b0, sy};
    assign dx_w = {1'b0, dx_q};
    assign dy_w = {1'b0, dy_q};

    assign slot_hit = shot_valid[idx_q] & alive_q & ~sy[9]
                    & (sx_w < dx_w + 11'(DUCK_W)) & (sx_w + 11'(SHOT_W) > dx_w)
                    & (sy_w < dy_w + 11'(DUCK_H)) & (sy_w + 11'(SHOT_H) > dy_w);

    always_comb begin
`ifdef MULTI_HIT_EN
        mask_d = mask_q | ({7'b0, slot_hit} << idx_q);
`else
        mask_d = mask_q;
        if (slot_hit && mask_q == 8'd0)
            mask_d = 8'd1 << idx_q;
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            hit_q   <= 1'b0;
            slot_q  <= 3'd0;
            kill_q  <= 8'd0;
            score_q <= 10'd0;
            idx_q   <= 3'd0;
            mask_q  <= 8'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    hit_q  <= 1'b0;
                    kill_q <= 8'd0;
                    if (scan_start) begin
                        dx_q    <= duck_x;
                        dy_q    <= duck_y;
                        alive_q <= duck_alive;
                        mask_q  <= 8'd0;
                        idx_q   <= 3'd0;
                        busy_q  <= 1'b1;
                        state_q <= SCAN;
                    end
                end
                SCAN: begin
                    mask_q <= mask_d;
                    idx_q  <= idx_q + 3'd1;
                    // Final slot folds straight into the registered report so it is visible during REPORT
                    if (idx_q == 3'd7) begin
                        state_q <= REPORT;
                        if (mask_d != 8'd0) begin
                            hit_q  <= 1'b1;
                            kill_q <= mask_d;
                            slot_q <= lowest_set(mask_d);
                        end
                        score_q <= sat_add(score_q, popcount(mask_d));
                    end
                end
                REPORT: begin
                    hit_q   <= 1'b0;
                    kill_q  <= 8'd0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy      = busy_q;
    assign hit       = hit_q;
    assign hit_slot  = slot_q;
    assign kill_mask = kill_q;
    assign score     = score_q;

endmodule
